// File: rtl/matrix_stream_store.sv
// Matrix store: per-scale age-ordered index over a flat element memory, streamed in/out row-major.
// Latency: command response or first element one cycle after accept; one RSP cycle closes every op.
// Backpressure: cmd_ready only in IDLE, in_ready only in WR, out_data/out_last hold while out_ready=0.
module matrix_stream_store #(
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_SIZE     = 5,
  parameter int MATRIX_NUM   = 8,
  parameter int MAX_PER_SIZE = 4,
  localparam int SLOT_W = (MATRIX_NUM > 1) ? $clog2(MATRIX_NUM) : 1,
  localparam int IDX_W  = (MAX_PER_SIZE > 1) ? $clog2(MAX_PER_SIZE) : 1,
  localparam int CNT_W  = $clog2(MAX_PER_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [2:0]            cmd_row,
  input  logic [2:0]            cmd_col,
  input  logic [IDX_W-1:0]      cmd_idx,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic                  rsp_evict,
  output logic [SLOT_W-1:0]     rsp_slot,
  input  logic [2:0]            q_row,
  input  logic [2:0]            q_col,
  output logic [CNT_W-1:0]      q_cnt,
  output logic [SLOT_W:0]       free_cnt
);

  localparam int NS    = MAX_SIZE * MAX_SIZE;
  localparam int DEPTH = MATRIX_NUM * NS;
  localparam int SC_W  = (NS > 1) ? $clog2(NS) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW    = $clog2(NS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_RSP  = 2'd3;

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] mem     [DEPTH];
  logic [CNT_W-1:0]      cnt_tab [NS];
  logic [SLOT_W-1:0]     idx_tab [NS][MAX_PER_SIZE];
  logic [MATRIX_NUM-1:0] used;

  logic [SC_W-1:0]       op_sc;
  logic [SLOT_W-1:0]     op_slot;
  logic                  op_evict;
  logic [EW-1:0]         el_k;
  logic [EW-1:0]         el_last;
  logic [DATA_WIDTH-1:0] rd_dat;
  logic                  r_err;
  logic                  r_evict;
  logic [SLOT_W-1:0]     r_slot;

  function automatic logic dims_ok(input logic [2:0] r, input logic [2:0] c);
    return (r != 3'd0) && (int'(r) <= MAX_SIZE) && (c != 3'd0) && (int'(c) <= MAX_SIZE);
  endfunction

  function automatic logic [SC_W-1:0] scale_of(input logic [2:0] r, input logic [2:0] c);
    return SC_W'((int'(r) - 1) * MAX_SIZE + int'(c) - 1);
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic [SLOT_W-1:0] s, input logic [EW-1:0] k);
    return AW'(int'(s) * NS + int'(k));
  endfunction

  logic [SC_W-1:0]   c_sc;
  logic              c_dims;
  logic [CNT_W-1:0]  c_cnt;
  logic              c_full;
  logic              c_idx_ok;
  logic [SLOT_W-1:0] c_idx_slot;
  logic [SC_W-1:0]   q_sc;

  assign c_sc       = scale_of(cmd_row, cmd_col);
  assign c_dims     = dims_ok(cmd_row, cmd_col);
  assign c_cnt      = cnt_tab[c_sc];
  assign c_full     = (int'(c_cnt) == MAX_PER_SIZE);
  assign c_idx_ok   = c_dims && (int'(cmd_idx) < int'(c_cnt));
  assign c_idx_slot = idx_tab[c_sc][cmd_idx];

  logic              free_any;
  logic [SLOT_W-1:0] free_slot;

  always_comb begin
    free_any  = 1'b0;
    free_slot = '0;
    free_cnt  = '0;
    for (int i = MATRIX_NUM - 1; i >= 0; i--) begin
      if (!used[i]) begin
        free_any  = 1'b1;
        free_slot = SLOT_W'(i);
        free_cnt  = free_cnt + (SLOT_W + 1)'(1);
      end
    end
  end

  assign q_sc  = scale_of(q_row, q_col);
  assign q_cnt = dims_ok(q_row, q_col) ? cnt_tab[q_sc] : '0;

  assign cmd_ready = rst_n && (state == S_IDLE);
  assign in_ready  = (state == S_WR);
  assign out_valid = (state == S_RD);
  assign out_data  = out_valid ? rd_dat : '0;
  assign out_last  = out_valid && (el_k == el_last);
  assign rsp_valid = (state == S_RSP);
  assign rsp_err   = rsp_valid && r_err;
  assign rsp_evict = rsp_valid && r_evict;
  assign rsp_slot  = rsp_valid ? r_slot : '0;

  // Element memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (rst_n && state == S_WR && in_valid) mem[addr_of(op_slot, el_k)] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      used     <= '0;
      for (int i = 0; i < NS; i++) cnt_tab[i] <= '0;
      op_sc    <= '0;
      op_slot  <= '0;
      op_evict <= 1'b0;
      el_k     <= '0;
      el_last  <= '0;
      rd_dat   <= '0;
      r_err    <= 1'b0;
      r_evict  <= 1'b0;
      r_slot   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_err   <= 1'b0;
            r_evict <= 1'b0;
            r_slot  <= '0;
            op_sc   <= c_sc;
            el_k    <= '0;
            el_last <= EW'(int'(cmd_row) * int'(cmd_col) - 1);
            state   <= S_RSP;
            case (cmd_op)
              2'b00: begin
                if (!c_dims || (!c_full && !free_any)) begin
                  r_err <= 1'b1;
                end else begin
                  state    <= S_WR;
                  op_evict <= c_full;
                  op_slot  <= c_full ? idx_tab[c_sc][0] : free_slot;
                end
              end
              2'b01: begin
                if (!c_idx_ok) begin
                  r_err <= 1'b1;
                end else begin
                  state   <= S_RD;
                  op_slot <= c_idx_slot;
                  rd_dat  <= mem[addr_of(c_idx_slot, '0)];
                end
              end
              2'b10: begin
                if (!c_idx_ok) begin
                  r_err <= 1'b1;
                end else begin
                  r_slot             <= c_idx_slot;
                  used[c_idx_slot]   <= 1'b0;
                  cnt_tab[c_sc]      <= c_cnt - CNT_W'(1);
                  for (int i = 0; i < MAX_PER_SIZE - 1; i++) begin
                    if (i >= int'(cmd_idx)) idx_tab[c_sc][i] <= idx_tab[c_sc][i + 1];
                  end
                end
              end
              default: begin
                used <= '0;
                for (int i = 0; i < NS; i++) cnt_tab[i] <= '0;
              end
            endcase
          end
        end
        S_WR: begin
          if (in_valid) begin
            el_k <= el_k + EW'(1);
            if (el_k == el_last) begin
              state         <= S_RSP;
              r_slot        <= op_slot;
              r_evict       <= op_evict;
              used[op_slot] <= 1'b1;
              // Eviction drops index 0 and re-files its slot as the newest entry.
              if (op_evict) begin
                for (int i = 0; i < MAX_PER_SIZE - 1; i++) idx_tab[op_sc][i] <= idx_tab[op_sc][i + 1];
                idx_tab[op_sc][MAX_PER_SIZE - 1] <= op_slot;
              end else begin
                idx_tab[op_sc][IDX_W'(cnt_tab[op_sc])] <= op_slot;
                cnt_tab[op_sc] <= cnt_tab[op_sc] + CNT_W'(1);
              end
            end
          end
        end
        S_RD: begin
          if (out_ready) begin
            if (el_k == el_last) begin
              state  <= S_RSP;
              r_slot <= op_slot;
            end else begin
              el_k   <= el_k + EW'(1);
              rd_dat <= mem[addr_of(op_slot, el_k + EW'(1))];
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          r_err   <= 1'b0;
          r_evict <= 1'b0;
          r_slot  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_stream_store.sv
// Randomised bench for matrix_stream_store against a queue-based reference of the store.
module tb_matrix_stream_store;
  localparam int MS  = 5;
  localparam int MN  = 8;
  localparam int MPS = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_row, cmd_col;
  logic [1:0] cmd_idx;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic       out_valid, out_ready, out_last;
  logic [7:0] out_data;
  logic       rsp_valid, rsp_err, rsp_evict;
  logic [2:0] rsp_slot;
  logic [2:0] q_row, q_col;
  logic [2:0] q_cnt;
  logic [3:0] free_cnt;

  matrix_stream_store dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_idx(cmd_idx),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_evict(rsp_evict), .rsp_slot(rsp_slot),
    .q_row(q_row), .q_col(q_col), .q_cnt(q_cnt), .free_cnt(free_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;

  // Reference: per-scale queue of slots (front = oldest), slot occupancy, slot contents.
  int         sq [64][$];
  bit         used_m [MN];
  logic [7:0] sdata [MN][25];
  logic [7:0] wbuf [25];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit legal(input int r, input int c);
    return r >= 1 && r <= MS && c >= 1 && c <= MS;
  endfunction

  function automatic int mfree();
    int n = 0;
    for (int s = 0; s < MN; s++) if (!used_m[s]) n++;
    return n;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 64; k++) sq[k].delete();
    for (int s = 0; s < MN; s++) used_m[s] = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_state(input int r, input int c);
    q_row = 3'(r); q_col = 3'(c); #1;
    check("q_cnt", q_cnt, legal(r, c) ? sq[r * 8 + c].size() : 0);
    check("free_cnt", free_cnt, mfree());
  endtask

  task automatic issue(input logic [1:0] op, input int r, input int c, input int idx);
    int w = 0;
    while (!cmd_ready && w < 50) begin step(); w++; end
    if (!cmd_ready) check("cmd_timeout", cmd_ready, 1);
    check("idle_rsp_vld", rsp_valid, 0);
    cmd_valid = 1'b1; cmd_op = op; cmd_row = 3'(r); cmd_col = 3'(c); cmd_idx = 2'(idx);
    step();
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_row = 3'($urandom); cmd_col = 3'($urandom);
  endtask

  task automatic do_write(input int r, input int c);
    int key, slot, e, k, cyc;
    bit err, ev, acc;
    key = r * 8 + c; e = r * c; err = 0; ev = 0; slot = 0;
    if (!legal(r, c)) err = 1;
    else if (sq[key].size() == MPS) begin ev = 1; slot = sq[key][0]; end
    else begin
      slot = -1;
      for (int s = MN - 1; s >= 0; s--) if (!used_m[s]) slot = s;
      if (slot < 0) begin err = 1; slot = 0; end
    end
    issue(2'b00, r, c, 0);
    if (err) begin
      check("wr_err_vld", rsp_valid, 1);
      check("wr_err", rsp_err, 1);
      check("wr_err_slot", rsp_slot, 0);
      check("wr_err_in_rdy", in_ready, 0);
      chk_state(r, c);
      step();
      return;
    end
    check("wr_in_rdy", in_ready, 1);
    k = 0; cyc = 0;
    while (k < e && cyc < 400) begin
      if ($urandom_range(3) == 0) begin in_valid = 1'b0; in_data = 8'($urandom); end
      else begin in_valid = 1'b1; in_data = wbuf[k]; end
      acc = in_valid && in_ready;
      step(); cyc++;
      if (acc) k++;
    end
    in_valid = 1'b0;
    if (k < e) check("wr_timeout", k, e);
    check("wr_rsp_vld", rsp_valid, 1);
    check("wr_rsp_err", rsp_err, 0);
    check("wr_evict", rsp_evict, ev);
    check("wr_slot", rsp_slot, slot);
    if (ev) void'(sq[key].pop_front());
    sq[key].push_back(slot);
    used_m[slot] = 1'b1;
    for (int i = 0; i < e; i++) sdata[slot][i] = wbuf[i];
    chk_state(r, c);
    step();
  endtask

  task automatic do_read(input int r, input int c, input int idx);
    int key, slot, e, k, cyc;
    bit acc;
    key = r * 8 + c; e = r * c;
    issue(2'b01, r, c, idx);
    if (!legal(r, c) || idx >= sq[key].size()) begin
      check("rd_err_vld", rsp_valid, 1);
      check("rd_err", rsp_err, 1);
      check("rd_err_slot", rsp_slot, 0);
      check("rd_err_out_vld", out_valid, 0);
      step();
      return;
    end
    slot = sq[key][idx];
    k = 0; cyc = 0;
    while (k < e && cyc < 400) begin
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = cyc[0];
        default: out_ready = 1'($urandom_range(1));
      endcase
      check("rd_vld", out_valid, 1);
      check("rd_dat", out_data, sdata[slot][k]);
      check("rd_last", out_last, k == e - 1);
      acc = out_valid && out_ready;
      step(); cyc++;
      if (acc) k++;
    end
    out_ready = 1'b0;
    if (k < e) check("rd_timeout", k, e);
    check("rd_rsp_vld", rsp_valid, 1);
    check("rd_rsp_err", rsp_err, 0);
    check("rd_rsp_slot", rsp_slot, slot);
    check("rd_done_out_vld", out_valid, 0);
    step();
  endtask

  task automatic do_delete(input int r, input int c, input int idx);
    int key, slot;
    bit err;
    key = r * 8 + c;
    err = !legal(r, c) || idx >= sq[key].size();
    slot = err ? 0 : sq[key][idx];
    issue(2'b10, r, c, idx);
    check("del_vld", rsp_valid, 1);
    check("del_err", rsp_err, err);
    check("del_slot", rsp_slot, slot);
    if (!err) begin
      sq[key].delete(idx);
      used_m[slot] = 1'b0;
    end
    chk_state(r, c);
    step();
  endtask

  task automatic do_clear();
    issue(2'b11, 1, 1, 0);
    check("clr_vld", rsp_valid, 1);
    check("clr_err", rsp_err, 0);
    check("clr_slot", rsp_slot, 0);
    model_clear();
    chk_state(1, 1);
    step();
  endtask

  task automatic rand_wbuf();
    for (int i = 0; i < 25; i++) wbuf[i] = 8'($urandom);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, c, op;
    cmd_valid = 0; cmd_op = 0; cmd_row = 0; cmd_col = 0; cmd_idx = 0;
    in_valid = 0; in_data = 0; out_ready = 0; q_row = 2; q_col = 3;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_rdy", cmd_ready, 0);
    check("rst_in_rdy", in_ready, 0);
    check("rst_out_vld", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_rsp_vld", rsp_valid, 0);
    check("rst_rsp_slot", rsp_slot, 0);
    check("rst_q_cnt", q_cnt, 0);
    check("rst_free", free_cnt, MN);
    rst_n = 1'b1;
    step();
    check("post_rst_cmd_rdy", cmd_ready, 1);

    // 2x3 with elements 1..6, read back in full
    for (int i = 0; i < 6; i++) wbuf[i] = 8'(i + 1);
    do_write(2, 3);
    rdy_mode = 0;
    do_read(2, 3, 0);

    // five tagged 2x2 matrices: the fifth evicts the oldest
    do_clear();
    for (int t = 1; t <= 5; t++) begin
      for (int i = 0; i < 4; i++) wbuf[i] = 8'(t * 10 + i);
      do_write(2, 2);
    end
    do_read(2, 2, 0);
    do_read(2, 2, 3);

    // all slots full and scale not full: error, no WR
    do_clear();
    for (int t = 0; t < 4; t++) begin rand_wbuf(); do_write(1, 1); end
    for (int t = 0; t < 4; t++) begin rand_wbuf(); do_write(1, 2); end
    rand_wbuf();
    do_write(3, 3);

    // delete from the middle, then read the shifted entry
    do_delete(1, 1, 1);
    do_read(1, 1, 1);

    // stalled read of a 3x3
    rand_wbuf();
    do_write(3, 3);
    rdy_mode = 1;
    do_read(3, 3, 0);

    // reset in the middle of a 5x5 write
    do_clear();
    rand_wbuf();
    issue(2'b00, 5, 5, 0);
    for (int i = 0; i < 10; i++) begin in_valid = 1'b1; in_data = wbuf[i]; step(); end
    rst_n = 1'b0; in_valid = 1'b0;
    step();
    check("mid_rst_rsp_vld", rsp_valid, 0);
    check("mid_rst_in_rdy", in_ready, 0);
    rst_n = 1'b1;
    model_clear();
    step();
    check("post_mid_rst_rsp_vld", rsp_valid, 0);
    chk_state(5, 5);
    do_clear();
    chk_state(5, 5);
    do_read(0, 4, 0);

    // random traffic
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(9) == 0) begin r = $urandom_range(0, 7); c = $urandom_range(0, 7); end
      else begin r = $urandom_range(1, 3); c = $urandom_range(1, 3); end
      op = $urandom_range(0, 39);
      rdy_mode = $urandom_range(0, 2);
      if (op < 20) begin rand_wbuf(); do_write(r, c); end
      else if (op < 32) do_read(r, c, $urandom_range(0, 3));
      else if (op < 39) do_delete(r, c, $urandom_range(0, 3));
      else do_clear();
      chk_state($urandom_range(0, 7), $urandom_range(0, 7));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
